// File: rtl/keyboard_pkg.sv
// keyboard_pkg: link constants shared by both ends of the keyboard link, plus receiver FSM states
// KEYBOARD_RX_PARITY_EN adds the PARITY state
package keyboard_pkg;
    localparam int KBD_BIT_CYCLES = 5208;
    localparam int KBD_DATA_BITS  = 4;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef KEYBOARD_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a configurable reset value
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end
    assign o_q = r_q;
endmodule

// File: rtl/keyboard_rx.sv
// keyboard_rx: serial frame receiver for the keyboard link, pulses valid per good word
// Define KEYBOARD_RX_PARITY_EN to expect an even-parity bit between data and stop
module keyboard_rx
    import keyboard_pkg::*;
#(
    parameter int BIT_CYCLES = KBD_BIT_CYCLES,
    parameter int DATA_BITS  = KBD_DATA_BITS
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(DATA_BITS + 1);
`ifdef KEYBOARD_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_e AFTER_DATA = ST_STOP;
`endif

    rx_state_e            r_state, w_next;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_valid, r_ferr;
    logic                 w_rx, w_half, w_full, w_last, w_stop_hit, w_good, w_perr;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk(sysclk),
        .rst(rst),
        .i_d(rx_in),
        .o_q(w_rx)
    );

    assign w_half     = r_cnt == CW'(BIT_CYCLES / 2 - 1);
    assign w_full     = r_cnt == CW'(BIT_CYCLES - 1);
    assign w_last     = r_bit == BW'(DATA_BITS - 1);
    assign w_stop_hit = r_state == ST_STOP && w_full;
    assign w_good     = w_stop_hit && w_rx && !w_perr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      w_next = w_rx ? ST_IDLE : ST_START;
            ST_START:     if (w_half) w_next = w_rx ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_full && w_last) w_next = AFTER_DATA;
`ifdef KEYBOARD_RX_PARITY_EN
            ST_PARITY:    if (w_full) w_next = ST_STOP;
`endif
            ST_STOP:      if (w_full) w_next = w_rx ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: w_next = w_rx ? ST_IDLE : ST_WAIT_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_next;
            // restart the bit timer on every state change and at each mid-bit sample
            r_cnt   <= (r_state == ST_IDLE || w_next != r_state || w_full) ? '0 : r_cnt + CW'(1);
            r_bit   <= (r_state != ST_DATA) ? '0 : (w_full ? r_bit + BW'(1) : r_bit);
            if (r_state == ST_DATA && w_full)
                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (w_good)
                r_data <= r_shift;
            r_valid <= w_good;
            r_ferr  <= w_stop_hit && !w_good;
        end
    end

`ifdef KEYBOARD_RX_PARITY_EN
    logic r_perr;
    always_ff @(posedge sysclk) begin
        if (rst)
            r_perr <= 1'b0;
        else if (r_state == ST_START)
            r_perr <= 1'b0;
        else if (r_state == ST_PARITY && w_full)
            r_perr <= ^r_shift ^ w_rx;
    end
    assign w_perr = r_perr;
`else
    assign w_perr = 1'b0;
`endif

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = r_state != ST_IDLE;
endmodule
